// File: rtl/perf_event_monitor.sv
// rtl/perf_event_monitor.sv - event/cycle performance counters with RUN/FROZEN gating
//
// Purpose: counts per-cycle event strobes on NUM_EVENTS channels plus a
// free-running cycle counter while in RUN, freezes on halt, and exposes the
// totals through a registered read port. All counters saturate at max and set
// a sticky overflow flag.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     IDLE -> RUN
//   halt      RUN -> FROZEN
//   clear     zero counters and flags, return to IDLE (any state)
//   event_in  per-cycle event strobes, bit i feeds counter i
//   rd_sel    0..NUM_EVENTS-1 event counters, NUM_EVENTS cycle counter
//   rd_data   registered read data (0 for out-of-range select)
//   ovf       sticky saturation flags, bit NUM_EVENTS = cycle counter
//   state     00 IDLE, 01 RUN, 10 FROZEN
//   done      one-cycle pulse on the first cycle in FROZEN
module perf_event_monitor #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int SEL_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  clear,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic [NUM_EVENTS:0]   ovf,
  output logic [1:0]            state,
  output logic                  done
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_FROZEN = 2'b10;

  // Counter NUM_EVENTS is the cycle counter.
  localparam int NC = NUM_EVENTS + 1;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q [NC];
  logic [CNT_WIDTH-1:0] cnt_d [NC];
  logic [NUM_EVENTS:0]  ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_EVENTS:0]  inc;

  // The cycle counter's "event" is always asserted.
  assign inc = {1'b1, event_in};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    rd_data_d = '0;

    // Read captures the pre-increment value of this edge.
    if (rd_sel <= SEL_W'(NUM_EVENTS)) begin
      rd_data_d = cnt_q[rd_sel];
    end

    if (clear) begin
      // Events of a clear cycle are discarded.
      state_d = S_IDLE;
      ovf_d   = '0;
      for (int i = 0; i < NC; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          // The halt cycle itself is still counted.
          for (int i = 0; i < NC; i++) begin
            if (inc[i]) begin
              if (cnt_q[i] == {CNT_WIDTH{1'b1}}) begin
                ovf_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
              end
            end
          end
          if (halt) begin
            state_d = S_FROZEN;
            done_d  = 1'b1;
          end
        end
        S_FROZEN: begin
          state_d = S_FROZEN;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ovf_q     <= '0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < NC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < NC; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;
  assign state   = state_q;
  assign done    = done_q;

endmodule

// File: tb/tb_perf_event_monitor.sv
// tb/tb_perf_event_monitor.sv - randomized self-checking bench for perf_event_monitor
module tb_perf_event_monitor;

  logic        clk = 1'b0;
  logic        rst, start, halt, clear;
  logic [3:0]  event_in;
  logic [2:0]  rd_sel;
  logic [15:0] rd16;
  logic [3:0]  rd4;
  logic [4:0]  ovf16, ovf4;
  logic [1:0]  state16, state4;
  logic        done16, done4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear),
    .event_in(event_in), .rd_sel(rd_sel), .rd_data(rd16), .ovf(ovf16),
    .state(state16), .done(done16)
  );

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear),
    .event_in(event_in), .rd_sel(rd_sel), .rd_data(rd4), .ovf(ovf4),
    .state(state4), .done(done4)
  );

  // Reference: exact (unbounded) event totals; saturation and overflow are
  // derived from them when compared.
  typedef enum int { M_IDLE = 0, M_RUN = 1, M_FROZEN = 2 } mstate_t;
  mstate_t m_state;
  longint  m_cnt [5];
  bit      m_done;
  longint  exp_raw;
  bit      exp_valid;

  function automatic longint sat(input longint c, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  function automatic logic [4:0] ovf_of(input int w);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = m_cnt[i] > ((longint'(1) << w) - 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_done  = 1'b0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs.
  task automatic step(input bit st, input bit ha, input bit cl, input bit rs,
                      input logic [3:0] ev, input logic [2:0] sel);
    start = st; halt = ha; clear = cl; rst = rs; event_in = ev; rd_sel = sel;
    @(posedge clk);
    exp_valid = !rs && sel <= 3'd4;
    exp_raw   = exp_valid ? m_cnt[sel] : 0;
    if (rs) begin
      model_reset();
    end else if (cl) begin
      model_reset();
    end else begin
      m_done = (m_state == M_RUN) && ha;
      if (m_state == M_RUN) begin
        m_cnt[4] += 1;
        for (int i = 0; i < 4; i++) m_cnt[i] += ev[i];
        if (ha) m_state = M_FROZEN;
      end else if (m_state == M_IDLE && st) begin
        m_state = M_RUN;
      end
    end
    #1;
    chk("state16", 32'(state16), 32'(m_state));
    chk("state4",  32'(state4),  32'(m_state));
    chk("done16",  32'(done16),  32'(m_done));
    chk("done4",   32'(done4),   32'(m_done));
    chk("ovf16",   32'(ovf16),   32'(ovf_of(16)));
    chk("ovf4",    32'(ovf4),    32'(ovf_of(4)));
    // rd_data after a clear edge holds a pre-clear value; only check otherwise.
    if (!cl || rs) begin
      chk("rd16", 32'(rd16), 32'(sat(exp_raw, 16)));
      chk("rd4",  32'(rd4),  32'(sat(exp_raw, 4)));
    end
  endtask

  task automatic idle_cycles(input int n, input logic [2:0] sel);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'($urandom), sel);
  endtask

  initial begin
    int basic_exp [5];
    basic_exp = '{10, 0, 10, 0, 10};
    model_reset();
    start = 0; halt = 0; clear = 0; rst = 1; event_in = 0; rd_sel = 0;

    // Reset state
    step(0, 0, 0, 1, 4'h0, 3'd0);
    chk("reset_state", 32'(state16), 32'd0);
    chk("reset_rd",    32'(rd16),    32'd0);

    // Priority / ignore
    step(0, 1, 0, 0, 4'hF, 3'd4);
    chk("halt_in_idle", 32'(state16), 32'd0);
    step(1, 0, 1, 0, 4'hF, 3'd4);
    chk("start_clear", 32'(state16), 32'd0);
    idle_cycles(2, 3'd4);
    chk("start_clear_cnt", 32'(rd16), 32'd0);

    // Basic count: 10 RUN cycles, halt on the 10th
    step(1, 0, 0, 0, 4'h0, 3'd0);
    for (int i = 1; i <= 10; i++) step(0, i == 10, 0, 0, 4'b0101, 3'd0);
    chk("basic_done", 32'(done16), 32'd1);
    step(0, 1, 0, 0, 4'hF, 3'd0);
    chk("done_one_cycle", 32'(done16), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 4'hF, 3'(k));
      chk("basic_rd", 32'(rd16), 32'(basic_exp[k]));
    end
    step(1, 0, 0, 0, 4'hF, 3'd0);
    chk("start_in_frozen", 32'(state16), 32'd2);

    // Read latency and invalid select
    step(0, 0, 0, 0, 4'h0, 3'd0);
    step(0, 0, 0, 0, 4'h0, 3'd4);
    step(0, 0, 0, 0, 4'h0, 3'd7);
    chk("invalid_sel", 32'(rd16), 32'd0);

    // Saturation on the 4-bit instance
    step(0, 0, 1, 0, 4'h0, 3'd0);
    step(1, 0, 0, 0, 4'h0, 3'd0);
    for (int i = 1; i <= 20; i++) step(0, i == 20, 0, 0, 4'b0010, 3'd1);
    step(0, 0, 0, 0, 4'h0, 3'd1);
    chk("sat_ev1", 32'(rd4), 32'd15);
    step(0, 0, 0, 0, 4'h0, 3'd4);
    chk("sat_cyc", 32'(rd4), 32'd15);
    chk("sat_ovf", 32'(ovf4), 32'b10010);

    // Clear mid-run with events high, then restart
    step(0, 0, 1, 0, 4'h0, 3'd0);
    step(1, 0, 0, 0, 4'h0, 3'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 4'hF, 3'd0);
    step(0, 0, 1, 0, 4'hF, 3'd0);
    chk("clear_state", 32'(state16), 32'd0);
    chk("clear_ovf",   32'(ovf16),   32'd0);
    step(1, 0, 0, 0, 4'hF, 3'd0);
    for (int i = 1; i <= 3; i++) step(0, i == 3, 0, 0, 4'hF, 3'd0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 4'h0, 3'(k));
      chk("restart_rd", 32'(rd16), 32'd3);
    end

    // Reset mid-run
    step(0, 0, 1, 0, 4'h0, 3'd0);
    step(1, 0, 0, 0, 4'h0, 3'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 4'hF, 3'd4);
    step(0, 0, 0, 1, 4'hF, 3'd4);
    chk("rst_mid_state", 32'(state16), 32'd0);
    chk("rst_mid_rd",    32'(rd16),    32'd0);
    idle_cycles(3, 3'd4);
    chk("rst_needs_start", 32'(rd16), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0,
           4'($urandom), 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/perf_event_monitor.md
# perf_event_monitor

Parametrised, synthesizable performance-counter unit for the pipelined processor. It counts per-cycle event strobes (instruction retire, I/D cache requests and hits, stalls) on up to NUM_EVENTS channels plus a free-running cycle counter, gated by a RUN/FROZEN state machine. It freezes on halt so the totals can be read back through a registered read port. It sits beside the processor core inside the processor hierarchy and is fed by wires tapped from the fetch, memory and writeback stages.

## Interface
- NUM_EVENTS, 4, number of event channels (1..16)
- CNT_WIDTH, 16, width of every counter (4..32)
- SEL_W, $clog2(NUM_EVENTS+1), width of rd_sel (derived; do not override)

- clk  in  1  processor clock, rising-edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  begin counting (IDLE -> RUN)
- halt  in  1  processor halt seen in the memory/writeback stage (RUN -> FROZEN)
- clear  in  1  zero all counters and flags, return to IDLE
- event_in  in  NUM_EVENTS  per-cycle event strobes; bit i feeds counter i
- rd_sel  in  SEL_W  read select: 0..NUM_EVENTS-1 = event counters, NUM_EVENTS = cycle counter
- rd_data  out  CNT_WIDTH  registered read data
- ovf  out  NUM_EVENTS+1  sticky saturation flags; bit NUM_EVENTS belongs to the cycle counter
- state  out  2  00 IDLE, 01 RUN, 10 FROZEN
- done  out  1  one-cycle pulse on the first cycle in FROZEN

## Operation
- States:
  - IDLE: counters hold.
  - RUN: counting.
  - FROZEN: counters hold and are readable. Leaving FROZEN requires clear; start is ignored in this state.
- Transitions are evaluated at the rising edge. Priority: rst > clear > halt > start.
  - IDLE + start -> RUN.
  - RUN + halt -> FROZEN.
  - any state + clear -> IDLE.
  - halt in IDLE or FROZEN is ignored.
  - start in RUN is ignored.
- Counting in RUN, every cycle including the cycle halt is asserted:
  - cycle counter += 1.
  - counter i += 1 when event_in[i] = 1.
  - The start cycle itself is not counted; counting begins the cycle after start.
- Saturation: a counter at 2^CNT_WIDTH-1 that is asked to increment stays at max and sets its ovf bit. ovf bits stay set until clear or rst.
- clear in RUN zeroes counters on that edge; that cycle's events are discarded.
- rd_sel > NUM_EVENTS returns 0.
- Reads are legal in any state. Values are only guaranteed stable in IDLE and FROZEN.

## Timing
- Reset values: rd_data = 0, ovf = 0, state = IDLE, done = 0. All counters = 0.
- rd_data latency is 1 cycle. At edge t, rd_data captures the selected counter's value before that same edge's increment.
- done asserts for exactly one cycle, the cycle after the edge that entered FROZEN. It deasserts even if halt stays high.
- start and halt asserted together in IDLE: go to RUN (halt ignored, since it is not in RUN). The next halt in RUN then freezes.
- rst or clear mid-RUN: counters, ovf and done are zero on the next cycle, and state = IDLE.
- event_in is sampled only in RUN; it is don't-care in other states.
- No combinational path from any input to any output.

## Test plan
- Basic count (NUM_EVENTS=4, CNT_WIDTH=16): rst, start, 10 RUN cycles with event_in=4'b0101, halt on the 10th cycle. Required: done pulses once; state=10. Reading sel 0..4 yields 10, 0, 10, 0, 10.
- Priority/ignore: halt in IDLE -> state stays 00. start+clear together -> IDLE with counters 0. start in FROZEN -> stays 10.
- Saturation (CNT_WIDTH=4): event_in[1]=1 for 20 RUN cycles, then halt. Required: counters 1 and cycle read 15; ovf=5'b10010.
- Clear mid-run: 6 cycles with event_in=4'b1111, then clear with events high. Next cycle: all reads 0, ovf=0, state=00. Restart with start plus 3 cycles and halt -> every counter reads 3.
- Read latency/invalid select: in FROZEN, change rd_sel from 0 to 4 to 7. rd_data follows one cycle later, and rd_sel=7 gives 0x0000.
- Reset mid-RUN: assert rst for 1 cycle after 5 counted cycles. Required: outputs return to their reset values on the next cycle, and start is required again to count.
